// File: rtl/binary_to_bcd_seq.sv
// Multi-cycle binary-to-BCD converter using shift-and-add-3, one bit per clock.
// Optional two's complement input: the magnitude is converted and the sign is reported separately.
module binary_to_bcd_seq #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5,
  parameter int SIGNED = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      binary_input,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_output,
  output logic                  sign_output
);

  localparam int MIN_DIGITS = (WIDTH * 30103 + 99999) / 100000;
  localparam int CW         = $clog2(WIDTH + 1);

  if (WIDTH < 2) begin : g_width_check
    $error("binary_to_bcd_seq: WIDTH must be at least 2");
  end
  if (DIGITS < MIN_DIGITS) begin : g_digits_check
    $error("binary_to_bcd_seq: DIGITS too small to hold every WIDTH-bit value");
  end

  typedef enum logic {IDLE, CONV} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic                  w_accept;
  logic                  w_last;
  logic [CW-1:0]         r_count;
  logic [4*DIGITS-1:0]   r_bcd;
  logic [4*DIGITS-1:0]   w_adj;
  logic [4*DIGITS-1:0]   w_bcd_shift;
  logic [WIDTH-1:0]      r_bin;
  logic [WIDTH-1:0]      w_mag;
  logic                  w_neg;
  logic                  r_neg;
  logic                  r_done;
  logic [4*DIGITS-1:0]   r_bcd_out;
  logic                  r_sign_out;

  // WIDTH-bit negation read as unsigned already yields 2^(WIDTH-1) for the most negative input,
  // so it matches a WIDTH+1-bit magnitude without carrying an always-zero top bit.
  assign w_neg = (SIGNED != 0) && binary_input[WIDTH-1];
  assign w_mag = w_neg ? (~binary_input + {{(WIDTH-1){1'b0}}, 1'b1}) : binary_input;

  assign w_last = (r_count == CW'(WIDTH - 1));

  always_comb begin
    w_adj = r_bcd;
    for (int d = 0; d < DIGITS; d++) begin
      if (r_bcd[4*d +: 4] >= 4'd5) begin
        w_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
      end
    end
  end

  assign w_bcd_shift = {w_adj[4*DIGITS-2:0], r_bin[WIDTH-1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = CONV;
        end
      end
      CONV: begin
        if (w_last) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Results are published only on the final step, so the outputs never expose partial sums.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count    <= '0;
      r_bcd      <= '0;
      r_bin      <= '0;
      r_neg      <= 1'b0;
      r_done     <= 1'b0;
      r_bcd_out  <= '0;
      r_sign_out <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_count <= '0;
        r_bcd   <= '0;
        r_bin   <= w_mag;
        r_neg   <= w_neg;
      end else if (r_state == CONV) begin
        r_count <= r_count + CW'(1);
        r_bcd   <= w_bcd_shift;
        r_bin   <= {r_bin[WIDTH-2:0], 1'b0};
        if (w_last) begin
          r_bcd_out  <= w_bcd_shift;
          r_sign_out <= r_neg;
          r_done     <= 1'b1;
        end
      end
    end
  end

  assign busy        = (r_state == CONV);
  assign done        = r_done;
  assign bcd_output  = r_bcd_out;
  assign sign_output = (SIGNED != 0) ? r_sign_out : 1'b0;

endmodule

// File: tb/tb_binary_to_bcd_seq.sv
// Directed self-checking bench: an unsigned 16-bit/5-digit instance and a signed 8-bit/3-digit instance.
module tb_binary_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] binaryInput;
  logic        busy;
  logic        done;
  logic [19:0] bcdOutput;
  logic        signOutput;

  logic        sStart;
  logic [7:0]  sInput;
  logic        sBusy;
  logic        sDone;
  logic [11:0] sBcd;
  logic        sSign;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  binary_to_bcd_seq #(.WIDTH(16), .DIGITS(5), .SIGNED(0)) dutU (
    .clk(clk), .rst(rst), .start(start), .binary_input(binaryInput),
    .busy(busy), .done(done), .bcd_output(bcdOutput), .sign_output(signOutput)
  );

  binary_to_bcd_seq #(.WIDTH(8), .DIGITS(3), .SIGNED(1)) dutS (
    .clk(clk), .rst(rst), .start(sStart), .binary_input(sInput),
    .busy(sBusy), .done(sDone), .bcd_output(sBcd), .sign_output(sSign)
  );

  // Drive start for exactly one edge; returns at the falling edge after the accepting edge.
  task automatic pulse_start(input bit sel, input logic [15:0] value);
    @(negedge clk);
    if (sel) begin
      sInput = value[7:0];
      sStart = 1'b1;
    end else begin
      binaryInput = value;
      start       = 1'b1;
    end
    @(negedge clk);
    sStart = 1'b0;
    start  = 1'b0;
  endtask

  // Count falling edges until done rises (bounded); busyOk drops if busy is low before done or high with it.
  task automatic wait_done(input bit sel, output int cycles, output bit busyOk);
    cycles = 0;
    busyOk = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (sel ? sDone : done) begin
        cycles = n;
        if (sel ? sBusy : busy) busyOk = 1'b0;
        break;
      end
      if (!(sel ? sBusy : busy)) busyOk = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst         = 1'b1;
    start       = 1'b0;
    binaryInput = 16'd0;
    sStart      = 1'b0;
    sInput      = 8'd0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, bcdOutput, signOutput} !== 23'd0) begin
      failures++;
      $display("[TB] FAIL reset_unsigned: got busy=%b done=%b bcd=%h sign=%b expected all zero",
               busy, done, bcdOutput, signOutput);
    end
    checks++;
    if ({sBusy, sDone, sBcd, sSign} !== 15'd0) begin
      failures++;
      $display("[TB] FAIL reset_signed: got busy=%b done=%b bcd=%h sign=%b expected all zero",
               sBusy, sDone, sBcd, sSign);
    end
    rst = 1'b0;
  endtask

  task automatic test_conversions;
    logic [15:0] vIn [10]  = '{16'd0, 16'd1, 16'd9, 16'd10, 16'd99, 16'd100,
                               16'd9999, 16'd12345, 16'd32768, 16'd65535};
    logic [19:0] vExp [10] = '{20'h00000, 20'h00001, 20'h00009, 20'h00010, 20'h00099, 20'h00100,
                               20'h09999, 20'h12345, 20'h32768, 20'h65535};
    int cycles;
    bit busyOk;
    for (int i = 0; i < 10; i++) begin
      pulse_start(1'b0, vIn[i]);
      checks++;
      if (busy !== 1'b1) begin
        failures++;
        $display("[TB] FAIL busy_after_start[%0d]: got %b expected 1", i, busy);
      end
      wait_done(1'b0, cycles, busyOk);
      checks++;
      if (cycles !== 16) begin
        failures++;
        $display("[TB] FAIL latency[%0d]: got %0d expected 16", i, cycles);
      end
      checks++;
      if (busyOk !== 1'b1) begin
        failures++;
        $display("[TB] FAIL busy_profile[%0d]: got bad busy during conversion expected busy until done", i);
      end
      checks++;
      if (bcdOutput !== vExp[i] || signOutput !== 1'b0) begin
        failures++;
        $display("[TB] FAIL convert[%0d]: got bcd=%h sign=%b expected bcd=%h sign=0",
                 i, bcdOutput, signOutput, vExp[i]);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("[TB] FAIL done_one_cycle[%0d]: got done=%b busy=%b expected 0 0", i, done, busy);
      end
    end
  endtask

  task automatic test_ignore_start_while_busy;
    int cycles;
    bit busyOk;
    bit sawDone;
    bit bcdMoved;
    pulse_start(1'b0, 16'd1234);
    repeat (3) @(negedge clk);
    binaryInput = 16'd4321;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(1'b0, cycles, busyOk);
    checks++;
    if (cycles + 4 !== 16) begin
      failures++;
      $display("[TB] FAIL ignore_latency: got %0d expected 16", cycles + 4);
    end
    checks++;
    if (bcdOutput !== 20'h01234) begin
      failures++;
      $display("[TB] FAIL ignore_result: got %h expected 01234", bcdOutput);
    end
    sawDone  = 1'b0;
    bcdMoved = 1'b0;
    for (int n = 0; n < 24; n++) begin
      binaryInput = 16'(n * 2731);
      @(negedge clk);
      if (done || busy) sawDone = 1'b1;
      if (bcdOutput !== 20'h01234) bcdMoved = 1'b1;
    end
    checks++;
    if (sawDone !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ignore_no_second_done: got extra done/busy expected none");
    end
    checks++;
    if (bcdMoved !== 1'b0) begin
      failures++;
      $display("[TB] FAIL hold_output: got %h expected 01234 held", bcdOutput);
    end
  endtask

  task automatic test_back_to_back;
    int cycles;
    bit busyOk;
    @(negedge clk);
    binaryInput = 16'd100;
    start       = 1'b1;
    @(negedge clk);
    binaryInput = 16'd7;
    wait_done(1'b0, cycles, busyOk);
    checks++;
    if (cycles !== 16 || bcdOutput !== 20'h00100) begin
      failures++;
      $display("[TB] FAIL b2b_first: got cycles=%0d bcd=%h expected cycles=16 bcd=00100", cycles, bcdOutput);
    end
    wait_done(1'b0, cycles, busyOk);
    start = 1'b0;
    checks++;
    if (cycles !== 17 || busyOk !== 1'b1) begin
      failures++;
      $display("[TB] FAIL b2b_spacing: got %0d busyOk=%b expected 17 1", cycles, busyOk);
    end
    checks++;
    if (bcdOutput !== 20'h00007) begin
      failures++;
      $display("[TB] FAIL b2b_second: got %h expected 00007", bcdOutput);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL b2b_stop: got busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_reset_mid_conversion;
    int cycles;
    bit busyOk;
    pulse_start(1'b0, 16'd54321);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || bcdOutput !== 20'h00000) begin
      failures++;
      $display("[TB] FAIL reset_mid: got busy=%b done=%b bcd=%h expected 0 0 00000", busy, done, bcdOutput);
    end
    @(negedge clk);
    rst = 1'b0;
    pulse_start(1'b0, 16'd42);
    wait_done(1'b0, cycles, busyOk);
    checks++;
    if (cycles !== 16 || bcdOutput !== 20'h00042) begin
      failures++;
      $display("[TB] FAIL after_reset: got cycles=%0d bcd=%h expected cycles=16 bcd=00042", cycles, bcdOutput);
    end
  endtask

  task automatic test_signed;
    logic [7:0]  vIn [6]   = '{8'h80, 8'h7F, 8'hFF, 8'h00, 8'h9C, 8'h05};
    logic [11:0] vExp [6]  = '{12'h128, 12'h127, 12'h001, 12'h000, 12'h100, 12'h005};
    logic        vSign [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    int cycles;
    bit busyOk;
    for (int i = 0; i < 6; i++) begin
      pulse_start(1'b1, {8'd0, vIn[i]});
      wait_done(1'b1, cycles, busyOk);
      checks++;
      if (cycles !== 8 || busyOk !== 1'b1) begin
        failures++;
        $display("[TB] FAIL signed_latency[%0d]: got %0d busyOk=%b expected 8 1", i, cycles, busyOk);
      end
      checks++;
      if (sBcd !== vExp[i] || sSign !== vSign[i]) begin
        failures++;
        $display("[TB] FAIL signed_convert[%0d]: got bcd=%h sign=%b expected bcd=%h sign=%b",
                 i, sBcd, sSign, vExp[i], vSign[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_conversions();
    test_ignore_start_while_busy();
    test_back_to_back();
    test_reset_mid_conversion();
    test_signed();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
